// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS-subset control unit.
// Moore FSM (FETCH/DECODE/MEM/EXEC/WB/BRANCH/JUMP/TRAP/ERR) with a memory
// wait-timeout watchdog that parks the controller in ERR until reset.
// Optional feature: define MC_CONTROL_BEQ_EN to decode BEQ (opcode 000100)
// into BRANCH; otherwise BEQ is treated as an illegal instruction (TRAP).
module mc_control #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem2reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [5:0] alu_op,
   output logic [3:0] state,
   output logic       illegal,
   output logic       bus_err
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_WB_MEM   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_WB_R     = 4'd7,
      S_EXEC_I   = 4'd8,
      S_WB_I     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_TRAP     = 4'd12,
      S_ERR      = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_SUB  = 6'b100010;

   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       in_mem;

   // State and wait-counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state decode, timeout watchdog and wait-counter update
   always_comb begin
      state_d = state_q;
      in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_RTYPE)                        state_d = S_EXEC_R;
            else if (opcode == OP_ADDI)                    state_d = S_EXEC_I;
            else if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEM_ADDR;
            else if (opcode == OP_J)                       state_d = S_JUMP;
`ifdef MC_CONTROL_BEQ_EN
            else if (opcode == OP_BEQ)                     state_d = S_BRANCH;
`endif
            else                                           state_d = S_TRAP;
         end
         S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_WB_MEM:   state_d = S_FETCH;
         S_EXEC_R:   state_d = S_WB_R;
         S_WB_R:     state_d = S_FETCH;
         S_EXEC_I:   state_d = S_WB_I;
         S_WB_I:     state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_TRAP:     state_d = S_FETCH;
         S_ERR:      state_d = S_ERR;
         default:    state_d = S_FETCH;
      endcase

      // A further low cycle once the budget is spent is a bus fault
      if (in_mem && !mem_ready && (wait_q == TIMEOUT_C)) state_d = S_ERR;

      // Counter clears whenever the state changes, so entry into a memory
      // state always starts from zero
      if (!in_mem || mem_ready || (state_d != state_q)) wait_d = '0;
      else                                              wait_d = wait_q + 8'd1;
   end

   // Moore output decode; write enables are forced low while reset is held
   always_comb begin
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      ir_write  = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem2reg   = 1'b0;
      reg_dst   = 1'b0;
      reg_write = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = ALU_ADD;
      illegal   = 1'b0;
      bus_err   = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_DECODE:   alu_src_b = 2'b11;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_WB_MEM: begin
            reg_write = 1'b1;
            mem2reg   = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = funct;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_WB_I:     reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'b01;
            pc_write  = zero;
         end
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         S_TRAP:     illegal = 1'b1;
         S_ERR:      bus_err = 1'b1;
         default: ;
      endcase
      if (reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: table of zero-wait instruction traces plus
// hand-written sequences for memory waits, timeout, and reset mid-access.
module tb_mc_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       mem2reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [5:0] alu_op;
   logic [3:0] state;
   logic       illegal;
   logic       bus_err;

   int unsigned checks = 0;
   int unsigned failures = 0;

   mc_control #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
      .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .mem2reg(mem2reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .state(state), .illegal(illegal), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] ADD = 6'b100000;
   localparam logic [5:0] SUB = 6'b100010;
   localparam logic [5:0] SLT = 6'b101010;

   typedef struct {
      string          name;
      logic [5:0]     opcode;
      logic [5:0]     funct;
      logic           zero;
      int unsigned    n;
      logic [0:5][3:0] st;
      logic [0:5]     rw;
      logic [0:5]     pcw;
      logic [0:5]     mw;
      logic [0:5]     ill;
      logic [0:5][5:0] aop;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit after a reset edge with reset released
   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

      vecs[0] = '{"r_add", 6'b000000, ADD, 1'b0, 5, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0},
                  6'b000100, 6'b100010, 6'b000000, 6'b000000, {ADD,ADD,ADD,ADD,ADD,ADD}};
      vecs[1] = '{"r_sub", 6'b000000, SUB, 1'b0, 5, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0},
                  6'b000100, 6'b100010, 6'b000000, 6'b000000, {ADD,ADD,SUB,ADD,ADD,ADD}};
      vecs[2] = '{"r_slt_z1", 6'b000000, SLT, 1'b1, 5, {4'd0,4'd1,4'd6,4'd7,4'd0,4'd0},
                  6'b000100, 6'b100010, 6'b000000, 6'b000000, {ADD,ADD,SLT,ADD,ADD,ADD}};
      vecs[3] = '{"addi", 6'b001000, SLT, 1'b0, 5, {4'd0,4'd1,4'd8,4'd9,4'd0,4'd0},
                  6'b000100, 6'b100010, 6'b000000, 6'b000000, {ADD,ADD,ADD,ADD,ADD,ADD}};
      vecs[4] = '{"lw", 6'b100011, SUB, 1'b0, 6, {4'd0,4'd1,4'd2,4'd3,4'd4,4'd0},
                  6'b000010, 6'b100001, 6'b000000, 6'b000000, {ADD,ADD,ADD,ADD,ADD,ADD}};
      vecs[5] = '{"sw", 6'b101011, SUB, 1'b1, 5, {4'd0,4'd1,4'd2,4'd5,4'd0,4'd0},
                  6'b000000, 6'b100010, 6'b000100, 6'b000000, {ADD,ADD,ADD,ADD,ADD,ADD}};
      vecs[6] = '{"jump", 6'b000010, SUB, 1'b0, 4, {4'd0,4'd1,4'd11,4'd0,4'd0,4'd0},
                  6'b000000, 6'b101100, 6'b000000, 6'b000000, {ADD,ADD,ADD,ADD,ADD,ADD}};
      vecs[7] = '{"illegal", 6'b111111, SUB, 1'b1, 4, {4'd0,4'd1,4'd12,4'd0,4'd0,4'd0},
                  6'b000000, 6'b100100, 6'b000000, 6'b001000, {ADD,ADD,ADD,ADD,ADD,ADD}};
`ifdef MC_CONTROL_BEQ_EN
      vecs[8] = '{"beq_taken", 6'b000100, ADD, 1'b1, 4, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0},
                  6'b000000, 6'b101100, 6'b000000, 6'b000000, {ADD,ADD,SUB,ADD,ADD,ADD}};
      vecs[9] = '{"beq_not", 6'b000100, ADD, 1'b0, 4, {4'd0,4'd1,4'd10,4'd0,4'd0,4'd0},
                  6'b000000, 6'b100100, 6'b000000, 6'b000000, {ADD,ADD,SUB,ADD,ADD,ADD}};
`else
      vecs[8] = '{"beq_trap_z1", 6'b000100, ADD, 1'b1, 4, {4'd0,4'd1,4'd12,4'd0,4'd0,4'd0},
                  6'b000000, 6'b100100, 6'b000000, 6'b001000, {ADD,ADD,ADD,ADD,ADD,ADD}};
      vecs[9] = '{"beq_trap_z0", 6'b000100, ADD, 1'b0, 4, {4'd0,4'd1,4'd12,4'd0,4'd0,4'd0},
                  6'b000000, 6'b100100, 6'b000000, 6'b001000, {ADD,ADD,ADD,ADD,ADD,ADD}};
`endif

      // Reset state
      do_reset();
      chk("reset_state", state, 4'd0);
      chk("reset_bus_err", bus_err, 1'b0);
      chk("reset_illegal", illegal, 1'b0);
      chk("reset_mem_read", mem_read, 1'b1);
      chk("reset_alu_src_b", alu_src_b, 2'b01);

      // Zero-wait instruction traces
      for (int v = 0; v < 10; v++) begin
         opcode = vecs[v].opcode;
         funct  = vecs[v].funct;
         zero   = vecs[v].zero;
         do_reset();
         for (int unsigned i = 0; i < vecs[v].n; i++) begin
            chk({vecs[v].name, "_state"},     state,     vecs[v].st[i]);
            chk({vecs[v].name, "_reg_write"}, reg_write, vecs[v].rw[i]);
            chk({vecs[v].name, "_pc_write"},  pc_write,  vecs[v].pcw[i]);
            chk({vecs[v].name, "_mem_write"}, mem_write, vecs[v].mw[i]);
            chk({vecs[v].name, "_illegal"},   illegal,   vecs[v].ill[i]);
            chk({vecs[v].name, "_alu_op"},    alu_op,    vecs[v].aop[i]);
            if (vecs[v].st[i] == 4'd7) chk({vecs[v].name, "_reg_dst"}, reg_dst, 1'b1);
            if (vecs[v].st[i] == 4'd10 || vecs[v].st[i] == 4'd11)
               chk({vecs[v].name, "_pc_src"}, pc_src, (vecs[v].st[i] == 4'd10) ? 2'b01 : 2'b10);
            tick();
         end
      end

      // LW with three wait cycles in MEM_RD
      opcode = 6'b100011; funct = '0; zero = 1'b0;
      do_reset();
      tick(); tick(); tick();
      for (int k = 0; k < 3; k++) begin
         mem_ready = 1'b0;
         #1;
         chk("lw_wait_state", state, 4'd3);
         chk("lw_wait_i_or_d", i_or_d, 1'b1);
         chk("lw_wait_mem_read", mem_read, 1'b1);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      chk("lw_ready_state", state, 4'd3);
      tick();
      chk("lw_wb_state", state, 4'd4);
      chk("lw_wb_mem2reg", mem2reg, 1'b1);
      chk("lw_wb_reg_dst", reg_dst, 1'b0);
      tick();
      chk("lw_done_state", state, 4'd0);

      // 14 low cycles in FETCH is within budget
      opcode = 6'b000000;
      do_reset();
      mem_ready = 1'b0;
      for (int k = 0; k < 14; k++) tick();
      chk("fetch14_state", state, 4'd0);
      chk("fetch14_ir_write_low", ir_write, 1'b0);
      mem_ready = 1'b1;
      #1;
      chk("fetch14_ir_write", ir_write, 1'b1);
      tick();
      chk("fetch14_decode", state, 4'd1);

      // Timeout in FETCH: 15 counted waits, fault on the next low cycle
      do_reset();
      mem_ready = 1'b0;
      for (int k = 0; k < 15; k++) tick();
      chk("timeout_pre_state", state, 4'd0);
      chk("timeout_pre_bus_err", bus_err, 1'b0);
      tick();
      chk("timeout_state", state, 4'd13);
      chk("timeout_bus_err", bus_err, 1'b1);
      chk("timeout_mem_read", mem_read, 1'b0);
      mem_ready = 1'b1;
      tick(); tick(); tick();
      chk("err_held_state", state, 4'd13);
      chk("err_held_bus_err", bus_err, 1'b1);
      chk("err_held_pc_write", pc_write, 1'b0);
      do_reset();
      chk("err_reset_state", state, 4'd0);
      chk("err_reset_bus_err", bus_err, 1'b0);

      // Reset asserted while a store is waiting in MEM_WR
      opcode = 6'b101011;
      do_reset();
      tick(); tick(); tick();
      mem_ready = 1'b0;
      #1;
      chk("sw_wr_state", state, 4'd5);
      chk("sw_wr_mem_write", mem_write, 1'b1);
      tick();
      reset = 1'b1;
      #1;
      chk("sw_rst_cycle_mem_write", mem_write, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      chk("sw_rst_state", state, 4'd0);
      chk("sw_rst_mem_write", mem_write, 1'b0);
      chk("sw_rst_mem_read", mem_read, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max consecutive mem_ready-low wait cycles in any memory state before fault (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction[31:26] from instruction register.
REQ-005 funct  input  6  instruction[5:0] from instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory handshake; access completes in a cycle where mem_read or mem_write=1 and mem_ready=1.
REQ-008 pc_write  output  1  PC load enable.
REQ-009 pc_src  output  2  00 ALU result, 01 ALU out register (branch target), 10 jump target.
REQ-010 ir_write  output  1  instruction register load enable.
REQ-011 i_or_d  output  1  memory address select: 0 PC, 1 ALU out.
REQ-012 mem_read / mem_write  output  1 each  memory strobes.
REQ-013 mem2reg / reg_dst / reg_write  output  1 each  writeback data select (1=MDR), destination select (1=rd), register file write enable.
REQ-014 alu_src_a  output  1  0 PC, 1 register A; alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-015 alu_op  output  6  funct in EXEC_R, 6'b100010 (sub) in BRANCH, 6'b100000 (add) otherwise.
REQ-016 state  output  4  current state encoding; illegal  output  1  one-cycle pulse; bus_err  output  1  sticky fault.

Function
REQ-017 Moore FSM, encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, WB_MEM=4, MEM_WR=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11, TRAP=12, ERR=13; all outputs 0 in any state unless listed.
REQ-018 FETCH: mem_read=1, alu_src_b=01; ir_write=pc_write=1 only in the cycle mem_ready=1 (pc_src=00), then DECODE; else stay.
REQ-019 DECODE: alu_src_b=11 (branch target precompute); next by opcode: 000000->EXEC_R, 001000->EXEC_I, 100011/101011->MEM_ADDR, 000010->JUMP, 000100->BRANCH (if enabled), other->TRAP.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10; ->MEM_RD if LW else MEM_WR.
REQ-021 MEM_RD: mem_read=1, i_or_d=1; ->WB_MEM on mem_ready. MEM_WR: mem_write=1, i_or_d=1; ->FETCH on mem_ready.
REQ-022 WB_MEM: reg_write=1, mem2reg=1, reg_dst=0; ->FETCH.
REQ-023 EXEC_R: alu_src_a=1, alu_src_b=00 ->WB_R (reg_write=1, reg_dst=1) ->FETCH.
REQ-024 EXEC_I: alu_src_a=1, alu_src_b=10 ->WB_I (reg_write=1, reg_dst=0) ->FETCH.
REQ-025 BRANCH: alu_src_a=1, pc_src=01, pc_write=zero ->FETCH. JUMP: pc_src=10, pc_write=1 ->FETCH.
REQ-026 TRAP: illegal=1 for exactly one cycle ->FETCH; no register/memory/PC write.
REQ-027 8-bit wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR and on mem_ready=1; increments each cycle in those states with mem_ready=0; when it equals MEM_TIMEOUT ->ERR on next edge.
REQ-028 ERR: bus_err=1, all strobes/enables 0, terminal until reset.
REQ-029 funct ignored except in EXEC_R; zero ignored except in BRANCH.
REQ-030 Latencies with zero-wait memory: R/ADDI 4 cycles, LW 5, SW 4, BEQ/J 3, illegal 3.

Reset
REQ-031 reset=1 at an edge forces state=FETCH, wait counter=0, bus_err=0, regardless of current state, including mid-access or ERR.
REQ-032 Outputs follow REQ-018 for FETCH in the cycle after reset; no write strobe is asserted during the reset cycle itself.

Configuration
REQ-033 Macro MC_CONTROL_BEQ_EN: defined -> opcode 000100 enters BRANCH; undefined -> BRANCH state unreachable, 000100 goes to TRAP.

Verification
REQ-034 reset, opcode=000000, funct=100000, mem_ready=1 -> states 0,1,6,7,0; reg_write=1, reg_dst=1 only in state 7.
REQ-035 opcode=100011, mem_ready low 3 cycles in MEM_RD -> states 0,1,2,3,3,3,3,4,0; mem2reg=1 in 4.
REQ-036 opcode=000100, zero=1 -> pc_write=1, pc_src=01 in state 10; zero=0 -> pc_write=0 (macro defined); macro undefined -> state 12, illegal pulse.
REQ-037 opcode=111111 -> states 0,1,12,0; illegal=1 one cycle; reg_write=mem_write=pc_write=0 after FETCH.
REQ-038 MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> ERR after 15 wait cycles, bus_err=1 held; reset -> state 0, bus_err=0.
REQ-039 reset asserted during MEM_WR -> next state 0, mem_write=0.
